// File: rtl/kga_pkg.sv
// Shared constants, prefix-depth helper and result type for the Kogge-Stone adder.
// The optional input register stage is selected with the KGA_IN_REG_EN macro.
package kga_pkg;

  localparam int unsigned KGA_WIDTH = 8;

  function automatic int unsigned kga_levels(input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      if ((32'd1 << i) < width) n = i + 1;
    end
    return n;
  endfunction

  localparam int unsigned LEVELS = kga_levels(KGA_WIDTH);

  typedef struct packed {
    logic                 carry;
    logic [KGA_WIDTH-1:0] sum;
  } kga_res_t;

endpackage

// File: rtl/kga_pg_cell.sv
// Kogge-Stone prefix operator; BLACK=0 builds a gray cell whose group propagate is tied off.
module kga_pg_cell #(
  parameter logic BLACK = 1'b1
) (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g_o,
  output logic p_o
);

  always_comb begin
    g_o = gh | (ph & gl);
    p_o = BLACK ? (ph & pl) : 1'b0;
  end

endmodule

// File: rtl/kga_adder.sv
// Registered Kogge-Stone adder: {out_C,S} = A + B + in_C, latency 1 (2 with KGA_IN_REG_EN).
// Define KGA_IN_REG_EN to register A, B, in_C and in_valid ahead of the prefix tree.
module kga_adder
  import kga_pkg::*;
#(
  parameter int unsigned WIDTH = KGA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_C,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             out_C
);

  localparam int unsigned TREE_LEVELS = kga_levels(WIDTH);

  logic [WIDTH-1:0] a_t;
  logic [WIDTH-1:0] b_t;
  logic             cin_t;
  logic             vld_t;

`ifdef KGA_IN_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             vld_q, vld_d;

  always_comb begin
    a_d   = A;
    b_d   = B;
    cin_d = in_C;
    vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
      vld_q <= vld_d;
    end
  end

  assign a_t   = a_q;
  assign b_t   = b_q;
  assign cin_t = cin_q;
  assign vld_t = vld_q;
`else
  assign a_t   = A;
  assign b_t   = B;
  assign cin_t = in_C;
  assign vld_t = in_valid;
`endif

  logic [WIDTH-1:0] g_raw;
  logic [WIDTH-1:0] p_raw;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign g_raw = a_t & b_t;
  assign p_raw = a_t ^ b_t;

  // Level 0 folds in_C (generate at position -1) into bit 0, so after the
  // log2(WIDTH) span levels every node g[i] is the full group generate i..-1.
  // Each level keeps group propagate only for bits the next level still reads.
  for (genvar k = 0; k <= TREE_LEVELS; k++) begin : lvl
    localparam int unsigned SPAN  = (k == 0) ? 0 : (1 << (k - 1));
    localparam int unsigned P_LO  = (k == 0) ? 0 : (1 << k);
    localparam logic        HAS_P = (k == 0) || (k < TREE_LEVELS);

    logic [WIDTH-1:0] g;

    if (HAS_P) begin : pv
      logic [WIDTH-1:P_LO] p;
    end

    if (k == 0) begin : seed
      logic unused_p;

      assign pv.p          = p_raw;
      assign g[WIDTH-1:1]  = g_raw[WIDTH-1:1];

      kga_pg_cell #(.BLACK(1'b0)) u_cin (
        .gh  (g_raw[0]),
        .ph  (p_raw[0]),
        .gl  (cin_t),
        .pl  (1'b0),
        .g_o (g[0]),
        .p_o (unused_p)
      );
    end else begin : tree
      for (genvar i = 0; i < WIDTH; i++) begin : b
        if (i < SPAN) begin : pass
          assign g[i] = lvl[k-1].g[i];
        end else if (HAS_P && (i >= 2 * SPAN)) begin : black
          kga_pg_cell #(.BLACK(1'b1)) u_cell (
            .gh  (lvl[k-1].g[i]),
            .ph  (lvl[k-1].pv.p[i]),
            .gl  (lvl[k-1].g[i-SPAN]),
            .pl  (lvl[k-1].pv.p[i-SPAN]),
            .g_o (g[i]),
            .p_o (pv.p[i])
          );
        end else begin : gray
          logic unused_p;

          kga_pg_cell #(.BLACK(1'b0)) u_cell (
            .gh  (lvl[k-1].g[i]),
            .ph  (lvl[k-1].pv.p[i]),
            .gl  (lvl[k-1].g[i-SPAN]),
            .pl  (1'b0),
            .g_o (g[i]),
            .p_o (unused_p)
          );
        end
      end
    end
  end

  assign carry = {lvl[TREE_LEVELS].g[WIDTH-2:0], cin_t};
  assign cout  = lvl[TREE_LEVELS].g[WIDTH-1];
  assign sum   = lvl[0].pv.p ^ carry;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  always_comb begin
    v_d = vld_t;
    s_d = s_q;
    c_d = c_q;
    if (vld_t) begin
      s_d = sum;
      c_d = cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign S         = s_q;
  assign out_C     = c_q;
  assign out_valid = v_q;

endmodule

// File: tb/tb_kga_adder.sv
// Directed bench for kga_adder (WIDTH=8); latency follows KGA_IN_REG_EN.
module tb_kga_adder;
  import kga_pkg::*;

`ifdef KGA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       in_C;
  logic       out_valid;
  logic [7:0] S;
  logic       out_C;

  int n_cmp;
  int n_err;

  logic       pv_v [LAT];
  logic [7:0] pv_s [LAT];
  logic       pv_c [LAT];
  logic [7:0] held_s;
  logic       held_c;

  kga_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .in_C      (in_C),
    .out_valid (out_valid),
    .S         (S),
    .out_C     (out_C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic kga_res_t r(input logic c, input logic [7:0] s);
    kga_res_t x;
    x.carry = c;
    x.sum   = s;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < LAT; i++) begin
      pv_v[i] = 1'b0;
      pv_s[i] = 8'h00;
      pv_c[i] = 1'b0;
    end
    held_s = 8'h00;
    held_c = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, {7'd0, out_valid}, 8'h00);
    chk({tag, ".S"}, S, 8'h00);
    chk({tag, ".C"}, {7'd0, out_C}, 8'h00);
  endtask

  // Drive one cycle of inputs, then compare outputs against the entry LAT cycles old.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input kga_res_t exp, input string tag);
    in_valid = v;
    A        = a;
    B        = b;
    in_C     = c;
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv_v[i] = pv_v[i-1];
      pv_s[i] = pv_s[i-1];
      pv_c[i] = pv_c[i-1];
    end
    pv_v[0] = v;
    pv_s[0] = exp.sum;
    pv_c[0] = exp.carry;
    if (pv_v[LAT-1]) begin
      held_s = pv_s[LAT-1];
      held_c = pv_c[LAT-1];
    end
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, pv_v[LAT-1]});
    chk({tag, ".S"}, S, held_s);
    chk({tag, ".C"}, {7'd0, out_C}, {7'd0, held_c});
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    in_C     = 1'b0;
    clear_model();

    #2;
    check_zero("reset_noclk");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1'b1, 8'h00, 8'h00, 1'b0, r(1'b0, 8'h00), "zero");
    step(1'b1, 8'h00, 8'h00, 1'b1, r(1'b0, 8'h01), "cin_only");
    step(1'b1, 8'h01, 8'h01, 1'b0, r(1'b0, 8'h02), "one_one");
    step(1'b1, 8'hFF, 8'h00, 1'b1, r(1'b1, 8'h00), "full_chain");
    step(1'b1, 8'hFF, 8'hFF, 1'b0, r(1'b1, 8'hFE), "ff_ff");
    step(1'b1, 8'hFF, 8'hFF, 1'b1, r(1'b1, 8'hFF), "wrap");
    step(1'b0, 8'h33, 8'h44, 1'b1, r(1'b0, 8'h00), "drop1");

    step(1'b1, 8'h5A, 8'hA5, 1'b0, r(1'b0, 8'hFF), "alt");
    step(1'b1, 8'h80, 8'h80, 1'b0, r(1'b1, 8'h00), "msb");
    step(1'b1, 8'h0F, 8'h01, 1'b0, r(1'b0, 8'h10), "nibble");
    step(1'b1, 8'h7F, 8'h01, 1'b1, r(1'b0, 8'h81), "mid_chain");
    step(1'b1, 8'hC3, 8'h3C, 1'b1, r(1'b1, 8'h00), "prop_all");
    step(1'b1, 8'h12, 8'h34, 1'b1, r(1'b0, 8'h47), "plain");
    step(1'b0, 8'hAA, 8'hAA, 1'b0, r(1'b0, 8'h00), "drop2");
    step(1'b0, 8'h00, 8'hFF, 1'b1, r(1'b0, 8'h00), "idle");

    step(1'b1, 8'hAA, 8'h55, 1'b0, r(1'b0, 8'hFF), "pre_rst1");
    step(1'b1, 8'hF0, 8'h0F, 1'b1, r(1'b1, 8'h00), "pre_rst2");
    in_valid = 1'b1;
    A        = 8'h01;
    B        = 8'h02;
    in_C     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    clear_model();

    for (int i = 0; i < LAT; i++) begin
      step(1'b0, 8'h01, 8'h02, 1'b0, r(1'b0, 8'h00), "post_rst_idle");
    end
    step(1'b1, 8'h80, 8'h7F, 1'b1, r(1'b1, 8'h00), "post_rst1");
    step(1'b1, 8'h09, 8'h08, 1'b0, r(1'b0, 8'h11), "post_rst2");
    for (int i = 0; i < LAT; i++) begin
      step(1'b0, 8'hFF, 8'hFF, 1'b1, r(1'b0, 8'h00), "flush");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kga_adder.md
KGA_ADDER -- requirements
Module: kga_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits; legal values are powers of two, 2..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  qualifies A, B and in_C in the current cycle.
REQ-005 A  input  WIDTH  addend.
REQ-006 B  input  WIDTH  addend.
REQ-007 in_C  input  1  carry-in.
REQ-008 out_valid  output  1  S and out_C hold a valid result.
REQ-009 S  output  WIDTH  sum, A+B+in_C modulo 2^WIDTH.
REQ-010 out_C  output  1  carry-out, bit WIDTH of A+B+in_C.

Function
REQ-011 The block SHALL compute {out_C,S} = A + B + in_C, unsigned, with no truncation of the carry.
REQ-012 The carry network SHALL be a Kogge-Stone parallel prefix tree: per-bit generate g=A&B and propagate p=A^B, then log2(WIDTH) prefix levels at spans 1,2,4,...
REQ-013 in_C SHALL enter the tree as generate at position -1, so every bit's carry is resolved by the prefix tree, not by a ripple stage.
REQ-014 Final sum SHALL be S[i] = p[i] ^ c[i], with c[0] = in_C; out_C SHALL be the group generate of bits WIDTH-1..-1.
REQ-015 Without KGA_IN_REG_EN, S, out_C and out_valid SHALL be registered: the result of inputs sampled at edge N is visible after edge N, latency 1 cycle.
REQ-016 out_valid SHALL follow in_valid with the same latency; S/out_C SHALL update only when in_valid is 1 and SHALL hold their last value otherwise.
REQ-017 Back-to-back in_valid cycles SHALL yield one result per cycle; no stalls and no backpressure.
REQ-018 Wrap-around: all-ones + all-ones + 1 SHALL give S = all-ones and out_C = 1.

Reset
REQ-019 While rst_n = 0, S SHALL be 0, out_C SHALL be 0 and out_valid SHALL be 0, independent of clk.
REQ-020 Reset deassertion SHALL take effect at the next rising clk edge. The first valid result SHALL follow the first in_valid sampled after reset, with the REQ-015/REQ-024 latency.
REQ-021 Reset mid-operation SHALL discard every in-flight result, with no spurious out_valid afterwards.

Configuration
REQ-022 Macro KGA_IN_REG_EN SHALL control the optional input register stage.
REQ-023 Macro undefined: inputs feed the prefix tree combinationally, latency 1.
REQ-024 Macro defined: A, B, in_C and in_valid SHALL be registered (reset to 0) before the tree, latency 2; function is otherwise identical.

Structure
REQ-025 Shared package kga_pkg SHALL hold the WIDTH default (8), the stage-count function/constant LEVELS = clog2(WIDTH) and the result struct typedef {carry, sum}.
REQ-026 One sub-module kga_pg_cell SHALL implement the prefix operator (G = Gh | Ph&Gl, P = Ph&Pl). It is instantiated generatively per level and bit, with gray cells (G only) where P is unused.

Verification
REQ-027 A=0x00, B=0x00, in_C=0, in_valid=1 -> next cycle S=0x00, out_C=0, out_valid=1.
REQ-028 A=0x00, B=0x00, in_C=1 -> S=0x01, out_C=0. A=0x01, B=0x01, in_C=0 -> S=0x02, out_C=0.
REQ-029 A=0xFF, B=0x00, in_C=1 -> S=0x00, out_C=1 (full-length carry chain).
REQ-030 A=0xFF, B=0xFF, in_C=0 -> S=0xFE, out_C=1. A=0xFF, B=0xFF, in_C=1 -> S=0xFF, out_C=1.
REQ-031 Six vectors on consecutive cycles -> six consecutive out_valid results in order. Drop in_valid for one cycle -> out_valid=0 and S held.
REQ-032 Assert rst_n=0 mid-stream, asynchronously between edges -> S, out_C and out_valid go to 0 immediately. Repeat with KGA_IN_REG_EN defined, checking 2-cycle latency.
